mcd_bus_initiator: RTL

- Initiator end of the main-CPU bus protocol consumed by the Mega-CD core: turns queued register/memory commands into 68k-style bus cycles (addr, data, AS, OE, WE_HI/WE_LO, all strobes active-low).
- Used by the MCU/debug path to access the A12000 register window and the mapped BIOS/PRG/WRAM space without a real 68k.
- Holds a 2-entry command FIFO, a cycle sequencer with programmable phase lengths, and returns one response per command.

---
 rtl/mcd_bus_initiator.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mcd_bus_initiator.sv
// mcd_bus_initiator: turns queued register/memory commands into 68k-style bus cycles
// (SETUP -> STROBE -> HOLD) with active-low strobes and one response per command.
// Optional build macro MCD_INIT_TIMEOUT_EN: aborts a strobe stretched by bus_wait for
// TIMEOUT_CYC cycles and flags the response with rsp_err.
module mcd_bus_initiator #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        map_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [1:0]  cmd_be,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [23:0] bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_as,
    output logic        bus_oe,
    output logic        bus_we_hi,
    output logic        bus_we_lo,
    input  logic        bus_wait,
    output logic        busy
);
    localparam logic [3:0] SetupLast  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLast = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLast   = 4'(HOLD_CYC - 1);
    // FIFO entry layout: {we, be[1:0], addr[23:1], wdata[15:0]}
    localparam int unsigned EntryW = 42;

    typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [EntryW-1:0] fifo_mem [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              cmd_ready_q;
    logic              push, pop, finish, abort, timeout;
    logic              head_we;
    logic [1:0]        head_be;
    logic [22:0]       head_addr;
    logic [15:0]       head_wdata;
    logic              cur_we_q;
    logic [1:0]        cur_be_q;
    logic [23:0]       bus_addr_q;
    logic [15:0]       bus_dout_q;
    logic              as_q, oe_q, we_hi_q, we_lo_q;
    logic              as_d, oe_d, we_hi_d, we_lo_d;
    logic              rsp_valid_q, rsp_err_q;
    logic [15:0]       rsp_rdata_q;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = cmd_addr[0];
    assign push    = cmd_valid & cmd_ready_q;
    assign count_d = count_q + {1'b0, push} - {1'b0, pop};
    assign {head_we, head_be, head_addr, head_wdata} = fifo_mem[rd_ptr_q];

    // FIFO storage needs no reset; entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_we, cmd_be, cmd_addr[23:1], cmd_wdata};
        end
    end

    // FIFO pointers, occupancy and registered ready (drops as soon as the FIFO fills).
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            cmd_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q     <= count_d;
            cmd_ready_q <= (count_d != 2'd2);
        end
    end

`ifdef MCD_INIT_TIMEOUT_EN
    localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYC - 1);
    logic [9:0] tcnt_q;

    // Counts cycles spent in STROBE; zero on the first STROBE cycle.
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            tcnt_q <= 10'd0;
        end else begin
            tcnt_q <= (state_q == StStrobe) ? tcnt_q + 10'd1 : 10'd0;
        end
    end

    assign timeout = (state_q == StStrobe) && bus_wait && (tcnt_q == TimeoutLast);
`else
    logic unused_timeout;
    assign unused_timeout = ^10'(TIMEOUT_CYC);
    assign timeout        = 1'b0;
`endif

    // Sequencer state and phase counter.
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: phase lengths, bus_wait stretch and FIFO pop points.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                    cnt_d   = 4'd0;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    state_d = StStrobe;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StStrobe: begin
                if (timeout) begin
                    abort   = 1'b1;
                    state_d = StHold;
                    cnt_d   = 4'd0;
                end else if (cnt_q == StrobeLast) begin
                    // Final count cycle: bus_wait keeps us here without advancing.
                    if (!bus_wait) begin
                        finish  = 1'b1;
                        state_d = StHold;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = 4'd0;
                    if (count_q != 2'd0) begin
                        pop     = 1'b1;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Strobe next values from the next state so the pins come straight from flops.
    always_comb begin
        as_d    = 1'b1;
        oe_d    = 1'b1;
        we_hi_d = 1'b1;
        we_lo_d = 1'b1;
        if (state_d == StStrobe) begin
            as_d = 1'b0;
            if (cur_we_q) begin
                we_hi_d = ~cur_be_q[1];
                we_lo_d = ~cur_be_q[0];
            end else begin
                oe_d = 1'b0;
            end
        end
    end

    // Bus-side registers, latched command and response.
    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            as_q        <= 1'b1;
            oe_q        <= 1'b1;
            we_hi_q     <= 1'b1;
            we_lo_q     <= 1'b1;
            cur_we_q    <= 1'b0;
            cur_be_q    <= 2'b11;
            bus_addr_q  <= 24'd0;
            bus_dout_q  <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            as_q        <= as_d;
            oe_q        <= oe_d;
            we_hi_q     <= we_hi_d;
            we_lo_q     <= we_lo_d;
            rsp_valid_q <= finish | abort;
            if (pop) begin
                cur_we_q   <= head_we;
                cur_be_q   <= (head_be == 2'b00) ? 2'b11 : head_be;
                bus_addr_q <= {head_addr, 1'b0};
                bus_dout_q <= head_we ? head_wdata : 16'd0;
            end
            if (finish) begin
                rsp_rdata_q <= cur_we_q ? 16'd0 : bus_din;
                rsp_err_q   <= 1'b0;
            end else if (abort) begin
                rsp_rdata_q <= 16'd0;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_dout  = bus_dout_q;
    assign bus_as    = as_q;
    assign bus_oe    = oe_q;
    assign bus_we_hi = we_hi_q;
    assign bus_we_lo = we_lo_q;
    assign busy      = (count_q != 2'd0) | (state_q != StIdle);

endmodule
